md_scheduler: RTL and testbench
===============================

// Module: md_scheduler
// PURPOSE
//  Sequences the multiply/divide unit and its HI/LO registers for the 5-stage pipeline.
//  - Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage.
//  - Models multi-cycle latency with a countdown timer, then commits HI/LO.
//  - Produces md_stall, which is ORed into the existing D-stage hazard stall (PC/IR_D hold, IR_E clear).
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//  DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
// PORTS
//  clk        in   1   system clock, rising edge
//  reset      in   1   synchronous reset, active-low
//  start      in   1   E-stage instruction is an md op; sampled with md_op/rs_val/rt_val
//  md_op      in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 reserved
//  rs_val     in   32  forwarded rs operand (dividend / multiplicand / MTxx source)
//  rt_val     in   32  forwarded rt operand
//  md_use_D   in   1   D-stage instruction is any md op or MFHI/MFLO
//  busy       out  1   operation in flight
//  md_stall   out  1   = md_use_D & (busy | (start & md_op<=3))
//  hi, lo     out  32  architectural HI/LO, read by MFHI/MFLO in E
//  md_err     out  1   sticky protocol error flag
// BEHAVIOUR
//  Reset (reset==0 at an edge): state IDLE, cnt=0, busy=0, hi=lo=0, md_err=0.
//  Reset is also taken mid-operation: the in-flight result is discarded.
//  FSM: IDLE, RUN.
//  - IDLE & start & md_op<=3: latch result into hi_nx/lo_nx; cnt = MULT_CYCLES or DIV_CYCLES; go RUN.
//  - IDLE & start & md_op==4/5: hi (or lo) <= rs_val at that edge; stay IDLE; busy stays 0.
//  - RUN: cnt decrements each edge.
//  - RUN & cnt==1 at an edge: hi<=hi_nx, lo<=lo_nx, go IDLE.
//  Timing: busy is high for exactly N cycles after the start edge.
//  - New HI/LO are visible in cycle N+1; a start in that same cycle is accepted.
//  Arithmetic:
//  - MULT: signed 64-bit product. MULTU: unsigned. {hi,lo} = product.
//  - DIV/DIVU: lo = quotient truncated toward zero; hi = remainder, same sign as dividend.
//  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
//  Protocol errors (md_err<=1; operation ignored; state unchanged):
//  - start while busy
//  - reserved md_op
//  md_stall is combinational, with no register on the path.
// CONFIGURATION
//  MD_DIVZERO_HOLD_EN defined:
//  - DIV/DIVU with rt_val==0: hi/lo left unchanged; op completes after 1 busy cycle (cnt=1).
//  MD_DIVZERO_HOLD_EN undefined:
//  - divide by zero: lo=0xFFFFFFFF, hi=rs_val, full DIV_CYCLES latency.
// STRUCTURE
//  Shared package md_defs: md_op encodings (MD_MULT..MD_MTLO), FSM state encodings.
//  Those constants are also used by the decoder and type classifier.
//  Sub-module md_arith: combinational; (md_op, rs_val, rt_val) -> {hi_nx, lo_nx}.
//  - Contains the signed/unsigned multiply, divide, and divide-by-zero cases.
//  md_scheduler holds the FSM, counter, HI/LO registers, stall and error logic.
// TESTING
//  1. MULT rs=0xFFFFFFFE, rt=3 -> busy 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//  2. DIVU rs=7, rt=2 -> busy 10 cycles; then lo=3, hi=1.
//     DIV rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  3. MULTU, then md_use_D=1 on every busy cycle -> md_stall=1 on all 5 cycles.
//     md_stall=0 in cycle 6; MTLO in cycle 6 accepted.
//  4. start again while busy -> md_err=1; hi/lo get the first op's result only.
//  5. Reset pulled low at cnt==3 of a DIV -> next cycle busy=0, hi=lo=0, md_err=0.
//  6. DIV rt=0 -> HOLD_EN: 1 busy cycle, hi/lo unchanged.
//     No HOLD_EN: 10 cycles, lo=0xFFFFFFFF, hi=rs.

Source files
------------

// File: rtl/md_defs.sv
// Shared definitions for the multiply/divide scheduler: md_op encodings,
// FSM state encodings and small op-classification helpers. The decoder and
// the instruction type classifier use the same constants.
package md_defs;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    // MULT/MULTU/DIV/DIVU occupy the unit for several cycles.
    function automatic logic md_is_arith(input logic [2:0] op);
        return (op <= 3'd3);
    endfunction

    // Codes 6 and 7 are unassigned.
    function automatic logic md_is_reserved(input logic [2:0] op);
        return (op > 3'd5);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath: (md_op, rs_val, rt_val) -> {hi_nx, lo_nx}.
// Signed divide works on magnitudes, so 0x80000000 / -1 yields lo=0x80000000,
// hi=0 without relying on two's-complement overflow behaviour of '/'.
// Divide by zero returns lo=0xFFFFFFFF, hi=dividend.
module md_arith
    import md_defs::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] hi_nx,
    output logic [31:0] lo_nx
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] abs_rs;
    logic [31:0] abs_rt;
    logic [31:0] safe_rt;
    logic [31:0] safe_abs_rt;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic        rt_zero;
    md_op_e      op;

    assign op = md_op_e'(md_op);

    assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    assign prod_u = {32'b0, rs_val} * {32'b0, rt_val};

    assign rt_zero     = (rt_val == 32'd0);
    assign abs_rs      = rs_val[31] ? (32'd0 - rs_val) : rs_val;
    assign abs_rt      = rt_val[31] ? (32'd0 - rt_val) : rt_val;
    // Keep the dividers away from a zero divisor; the zero case is overridden below.
    assign safe_rt     = rt_zero ? 32'd1 : rt_val;
    assign safe_abs_rt = rt_zero ? 32'd1 : abs_rt;

    assign q_mag = abs_rs / safe_abs_rt;
    assign r_mag = abs_rs % safe_abs_rt;
    assign q_u   = rs_val / safe_rt;
    assign r_u   = rs_val % safe_rt;

    // Select the HI/LO pair the op will commit.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        hi_nx = 32'd0;
        lo_nx = 32'd0;
        case (op)
            MD_MULT: begin
                hi_nx = prod_s[63:32];
                lo_nx = prod_s[31:0];
            end
            MD_MULTU: begin
                hi_nx = prod_u[63:32];
                lo_nx = prod_u[31:0];
            end
            MD_DIV: begin
                if (rt_zero) begin
                    hi_nx = rs_val;
                    lo_nx = 32'hFFFF_FFFF;
                end else begin
                    lo_nx = (rs_val[31] ^ rt_val[31]) ? (32'd0 - q_mag) : q_mag;
                    hi_nx = rs_val[31] ? (32'd0 - r_mag) : r_mag;
                end
            end
            MD_DIVU: begin
                if (rt_zero) begin
                    hi_nx = rs_val;
                    lo_nx = 32'hFFFF_FFFF;
                end else begin
                    lo_nx = q_u;
                    hi_nx = r_u;
                end
            end
            default: begin
                hi_nx = 32'd0;
                lo_nx = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/md_scheduler.sv
// Multiply/divide scheduler: FSM, countdown timer, HI/LO registers, D-stage
// stall and sticky protocol-error flag. The result is computed at the start
// edge and committed to HI/LO when the countdown expires.
// Optional build macro MD_DIVZERO_HOLD_EN: DIV/DIVU by zero leaves HI/LO
// unchanged and completes after a single busy cycle.
module md_scheduler
    import md_defs::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_use_D,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        md_err
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic [31:0]       hi_nx_q, hi_nx_d;
    logic [31:0]       lo_nx_q, lo_nx_d;
    logic              err_q, err_d;

    logic [31:0]       arith_hi;
    logic [31:0]       arith_lo;
    logic              is_div;
    logic              op_err;
    md_op_e            op;

    md_arith u_arith (
        .md_op  (md_op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .hi_nx  (arith_hi),
        .lo_nx  (arith_lo)
    );

    assign op     = md_op_e'(md_op);
    assign is_div = (op == MD_DIV) || (op == MD_DIVU);
    // A start while the unit is busy, or with an unassigned code, is dropped and flagged.
    assign op_err = start & ((state_q == MD_RUN) | md_is_reserved(md_op));

    // Next-state, countdown, HI/LO and error-flag update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hi_nx_d = hi_nx_q;
        lo_nx_d = lo_nx_q;
        err_d   = err_q | op_err;

        case (state_q)
            MD_IDLE: begin
                if (start && !md_is_reserved(md_op)) begin
                    if (md_is_arith(md_op)) begin
                        hi_nx_d = arith_hi;
                        lo_nx_d = arith_lo;
                        cnt_d   = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state_d = MD_RUN;
`ifdef MD_DIVZERO_HOLD_EN
                        if (is_div && (rt_val == 32'd0)) begin
                            hi_nx_d = hi_q;
                            lo_nx_d = lo_q;
                            cnt_d   = CNT_W'(1);
                        end
`endif
                    end else if (op == MD_MTHI) begin
                        hi_d = rs_val;
                    end else begin
                        lo_d = rs_val;
                    end
                end
            end
            MD_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = hi_nx_q;
                    lo_d    = lo_nx_q;
                    state_d = MD_IDLE;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset; an in-flight op is discarded.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            // NOTE: the pending result is reset too so a discarded op can never leak into HI/LO.
            hi_nx_q <= 32'd0;
            lo_nx_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hi_nx_q <= hi_nx_d;
            lo_nx_q <= lo_nx_d;
            err_q   <= err_d;
        end
    end

    assign busy     = (state_q == MD_RUN);
    assign md_stall = md_use_D & (busy | (start & md_is_arith(md_op)));
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign md_err   = err_q;

endmodule

// File: tb/tb_md_scheduler.sv
// Self-checking bench for md_scheduler: a time-based reference model checked
// every cycle, plus directed scenarios with hand-computed literal results.
// Honours MD_DIVZERO_HOLD_EN in the same way as the design.
module tb_md_scheduler;
    import md_defs::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_use_D;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        md_err;

    int n_cmp = 0;
    int n_err = 0;

    md_scheduler #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .md_use_D (md_use_D),
        .busy     (busy),
        .md_stall (md_stall),
        .hi       (hi),
        .lo       (lo),
        .md_err   (md_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // An accepted op finishing at edge done_edge means the unit is busy after
    // every edge k < done_edge, and the result appears at edge done_edge.
    int          edge_n     = 0;
    int          done_edge  = 0;
    bit          model_valid = 1'b0;
    bit          pending    = 1'b0;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    bit          m_err;

    function automatic void model_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                         output logic [31:0] rh, output logic [31:0] rl, output int n);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        rh = 32'd0;
        rl = 32'd0;
        n  = MULT_N;
        if (op == MD_MULT) begin
            sp = sa * sb;
            rh = sp[63:32];
            rl = sp[31:0];
        end else if (op == MD_MULTU) begin
            up = ua * ub;
            rh = up[63:32];
            rl = up[31:0];
        end else begin
            n = DIV_N;
            if (b == 32'd0) begin
`ifdef MD_DIVZERO_HOLD_EN
                rh = m_hi;
                rl = m_lo;
                n  = 1;
`else
                rh = a;
                rl = 32'hFFFF_FFFF;
`endif
            end else if (op == MD_DIV) begin
                sq = sa / sb;
                sr = sa % sb;
                rh = sr[31:0];
                rl = sq[31:0];
            end else begin
                uq = ua / ub;
                ur = ua % ub;
                rh = ur[31:0];
                rl = uq[31:0];
            end
        end
    endfunction

    always @(posedge clk) begin : model
        int          k;
        bit          busy_before;
        logic [31:0] rh, rl;
        int          n;
        edge_n++;
        k = edge_n;
        busy_before = ((k - 1) < done_edge);
        if (!reset) begin
            m_hi = 32'd0;
            m_lo = 32'd0;
            m_err = 1'b0;
            pending = 1'b0;
            done_edge = k;
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (pending && (k == done_edge)) begin
                m_hi = p_hi;
                m_lo = p_lo;
                pending = 1'b0;
            end
            if (start) begin
                if (busy_before || (md_op > 3'd5)) begin
                    m_err = 1'b1;
                end else if (md_op <= 3'd3) begin
                    model_result(md_op, rs_val, rt_val, rh, rl, n);
                    p_hi = rh;
                    p_lo = rl;
                    pending = 1'b1;
                    done_edge = k + n;
                end else if (md_op == 3'd4) begin
                    m_hi = rs_val;
                end else begin
                    m_lo = rs_val;
                end
            end
        end
    end

    // Compare every cycle, mid-period, once the model has seen a reset.
    always @(negedge clk) begin : compare
        logic exp_busy;
        if (model_valid) begin
            exp_busy = (edge_n < done_edge);
            check("busy", {31'b0, busy}, {31'b0, exp_busy});
            check("md_stall", {31'b0, md_stall},
                  {31'b0, md_use_D & (exp_busy | (start & (md_op <= 3'd3)))});
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
            check("md_err", {31'b0, md_err}, {31'b0, m_err});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op for one cycle; returns in the first cycle after its start edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        md_op  = op;
        rs_val = a;
        rt_val = b;
        tick();
        start  = 1'b0;
    endtask

    // Counts busy cycles from the current one, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while ((busy === 1'b1) && (n < 200)) begin
            tick();
            n++;
        end
        check("idle_after_wait", {31'b0, busy}, 32'd0);
    endtask

    int          n;
    logic [31:0] exp_hi6, exp_lo6;
    int          exp_n6;

    initial begin
        reset = 1'b0; start = 1'b0; md_op = 3'd0;
        rs_val = 32'd0; rt_val = 32'd0; md_use_D = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_err", {31'b0, md_err}, 32'd0);

        // 1: signed multiply -2 * 3
        issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
        wait_idle(n);
        check("t1_cycles", n, 32'd5);
        check("t1_hi", hi, 32'hFFFF_FFFF);
        check("t1_lo", lo, 32'hFFFF_FFFA);

        // 2: unsigned / signed divide, second start in the cycle after completion
        issue(MD_DIVU, 32'd7, 32'd2);
        wait_idle(n);
        check("t2_cycles", n, 32'd10);
        check("t2_lo", lo, 32'd3);
        check("t2_hi", hi, 32'd1);
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        check("t2b_cycles", n, 32'd10);
        check("t2b_lo", lo, 32'hFFFF_FFFD);
        check("t2b_hi", hi, 32'hFFFF_FFFF);
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        check("t2c_lo", lo, 32'h8000_0000);
        check("t2c_hi", hi, 32'd0);

        // 3: stall on every busy cycle, then MTLO accepted in cycle 6
        md_use_D = 1'b1;
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
        for (int i = 0; i < 5; i++) begin
            check("t3_stall_busy", {31'b0, md_stall}, 32'd1);
            tick();
        end
        check("t3_busy6", {31'b0, busy}, 32'd0);
        start = 1'b1; md_op = MD_MTLO; rs_val = 32'h0000_1234;
        #1;
        check("t3_stall6", {31'b0, md_stall}, 32'd0);
        tick();
        start = 1'b0;
        md_use_D = 1'b0;
        check("t3_lo", lo, 32'h0000_1234);
        check("t3_hi", hi, 32'd1);
        check("t3_err", {31'b0, md_err}, 32'd0);

        // 4: start while busy is rejected and flagged
        issue(MD_MULT, 32'd3, 32'd4);
        issue(MD_DIVU, 32'd100, 32'd7);
        wait_idle(n);
        check("t4_cycles", n, 32'd4);
        check("t4_err", {31'b0, md_err}, 32'd1);
        check("t4_hi", hi, 32'd0);
        check("t4_lo", lo, 32'd12);

        // 5: reset when cnt==3 discards the divide
        issue(MD_DIV, 32'd1000, 32'd3);
        repeat (7) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("t5_busy", {31'b0, busy}, 32'd0);
        check("t5_hi", hi, 32'd0);
        check("t5_lo", lo, 32'd0);
        check("t5_err", {31'b0, md_err}, 32'd0);
        repeat (12) tick();
        check("t5_lo_late", lo, 32'd0);

        // 6: divide by zero
        issue(MD_MTHI, 32'h0000_AAAA, 32'd0);
        issue(MD_MTLO, 32'h0000_5555, 32'd0);
        issue(MD_DIV, 32'h0000_0077, 32'd0);
        wait_idle(n);
`ifdef MD_DIVZERO_HOLD_EN
        exp_n6 = 1; exp_hi6 = 32'h0000_AAAA; exp_lo6 = 32'h0000_5555;
`else
        exp_n6 = 10; exp_hi6 = 32'h0000_0077; exp_lo6 = 32'hFFFF_FFFF;
`endif
        check("t6_cycles", n, exp_n6);
        check("t6_hi", hi, exp_hi6);
        check("t6_lo", lo, exp_lo6);

        // Reserved op: flagged, nothing else changes
        issue(3'd6, 32'd1, 32'd1);
        check("rsv_err", {31'b0, md_err}, 32'd1);
        check("rsv_busy", {31'b0, busy}, 32'd0);
        check("rsv_hi", hi, exp_hi6);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
